multi_clk_en_gen: RTL

MULTI_CLK_EN_GEN -- requirements
Module: multi_clk_en_gen

---
 rtl/multi_clk_en_pkg.sv | 8 +
 rtl/clk_en_chan.sv | 60 ++++++
 rtl/multi_clk_en_gen.sv | 71 +++++++
 3 files changed

// File: rtl/multi_clk_en_pkg.sv
// multi_clk_en_pkg: lock FSM states and divide/phase clamp helpers shared by the enable generator
package multi_clk_en_pkg;
  typedef enum logic [1:0] {RST_WAIT, SETTLE, LOCKED} lock_state_e;
  localparam int unsigned MIN_DIV = 1;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan: one divider channel with shadowed div/phase that only takes effect on a counter wrap
module clk_en_chan
  import multi_clk_en_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  output logic             en_o,
  output logic             tgl_o,
  output logic             pend_o,
  output logic             apply_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d, phase_q, phase_d;
  logic [DIV_W-1:0] sdiv_q, sdiv_d, sphase_q, sphase_d;
  logic [DIV_W-1:0] last, eff_phase;
  logic pend_q, pend_d, en_q, en_d, tgl_q, tgl_d, wrap;
  always_comb begin
    last      = (div_q > DIV_W'(MIN_DIV)) ? div_q - DIV_W'(MIN_DIV) : '0;
    eff_phase = (phase_q > last) ? last : phase_q;
    wrap      = cnt_q == last;
    apply_o   = pend_q & wrap;
    cnt_d     = wrap ? '0 : cnt_q + 1'b1;
    en_d      = cnt_q == eff_phase;
    tgl_d     = tgl_q ^ en_d;
    div_d     = apply_o ? sdiv_q : div_q;
    phase_d   = apply_o ? sphase_q : phase_q;
    sdiv_d    = wr_i ? div_i : sdiv_q;
    sphase_d  = wr_i ? phase_i : sphase_q;
    pend_d    = wr_i | (pend_q & ~wrap);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      div_q    <= DIV_W'(DEF_DIV);
      phase_q  <= '0;
      sdiv_q   <= '0;
      sphase_q <= '0;
      pend_q   <= 1'b0;
      en_q     <= 1'b0;
      tgl_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      phase_q  <= phase_d;
      sdiv_q   <= sdiv_d;
      sphase_q <= sphase_d;
      pend_q   <= pend_d;
      en_q     <= en_d;
      tgl_q    <= tgl_d;
    end
  end
  assign en_o   = en_q;
  assign tgl_o  = tgl_q;
  assign pend_o = pend_q;
endmodule

// File: rtl/multi_clk_en_gen.sv
// multi_clk_en_gen: NUM_CH programmable clock-enable channels with single-write config port and lock FSM
module multi_clk_en_gen
  import multi_clk_en_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int DEF_DIV     = 2,
  parameter int LOCK_CYCLES = 256
) (
  input  logic                      refclk,
  input  logic                      rst,
  input  logic                      cfg_wr,
  input  logic [idx_w(NUM_CH)-1:0]  cfg_ch,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [DIV_W-1:0]          cfg_phase,
  output logic                      cfg_ready,
  output logic [NUM_CH-1:0]         outclk_en,
  output logic [NUM_CH-1:0]         outclk_tgl,
  output logic                      locked
);
  localparam int CH_W = idx_w(NUM_CH);
  localparam int LC_W = idx_w(LOCK_CYCLES);
  lock_state_e st_q, st_d;
  logic [LC_W-1:0] lcnt_q, lcnt_d;
  logic [NUM_CH-1:0] pend, apply;
  logic ready_q, ready_d, accept, pend_any;
  assign accept   = cfg_wr && ready_q && (int'(cfg_ch) < NUM_CH);
  assign pend_any = |pend;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_chan #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) u_ch (
      .clk_i  (refclk),
      .rst_i  (rst),
      .wr_i   (accept && (cfg_ch == CH_W'(i))),
      .div_i  (cfg_div),
      .phase_i(cfg_phase),
      .en_o   (outclk_en[i]),
      .tgl_o  (outclk_tgl[i]),
      .pend_o (pend[i]),
      .apply_o(apply[i])
    );
  end
  // only one write may be in flight, so ready stays low until its wrap applies it
  assign ready_d = ~(accept | (pend_any & ~|apply));
  always_comb begin
    st_d   = st_q;
    lcnt_d = lcnt_q;
    if (accept) begin
      st_d   = SETTLE;
      lcnt_d = '0;
    end else if (st_q == RST_WAIT) begin
      st_d   = SETTLE;
      lcnt_d = '0;
    end else if (st_q == SETTLE && !pend_any) begin
      st_d   = (lcnt_q == LC_W'(LOCK_CYCLES - 1)) ? LOCKED : SETTLE;
      lcnt_d = (lcnt_q == LC_W'(LOCK_CYCLES - 1)) ? lcnt_q : lcnt_q + 1'b1;
    end
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      st_q    <= RST_WAIT;
      lcnt_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      lcnt_q  <= lcnt_d;
      ready_q <= ready_d;
    end
  end
  assign cfg_ready = ready_q;
  assign locked    = st_q == LOCKED;
endmodule
